// File: rtl/ssd_scan_mux.sv
// Four-digit multiplexed seven-segment scanner. Captured values are held in a
// shadow register and swapped into the display only at frame boundaries.
module ssd_scan_mux #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic        blank_lz,
    output logic [3:0]  nibble_out,
    output logic [3:0]  anode,
    output logic        pending,
    output logic        frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [15:0]   display;
    logic          digit_tick;
    logic          frame_edge;
    logic          blanked;

    assign digit_tick = (prescaler == PS_LAST);
    assign frame_edge = digit_tick && (idx == 2'd3);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= 2'd0;
        end else if (digit_tick) begin
            prescaler <= '0;
            idx       <= idx + 2'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // A load landing on the boundary bypasses the shadow so it is not deferred a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow     <= 16'h0000;
            display    <= 16'h0000;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_edge;
            if (load && frame_edge) begin
                shadow  <= data_in;
                display <= data_in;
                pending <= 1'b0;
            end else if (load) begin
                shadow  <= data_in;
                pending <= 1'b1;
            end else if (frame_edge && pending) begin
                display <= shadow;
                pending <= 1'b0;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred
    // for index values a case item does not assign.
    always_comb begin
        nibble_out = display[3:0];
        blanked    = 1'b0;
        case (idx)
            2'd1: begin
                nibble_out = display[7:4];
                blanked    = blank_lz && (display[15:4] == 12'h000);
            end
            2'd2: begin
                nibble_out = display[11:8];
                blanked    = blank_lz && (display[15:8] == 8'h00);
            end
            2'd3: begin
                nibble_out = display[15:12];
                blanked    = blank_lz && (display[15:12] == 4'h0);
            end
            default: begin
                nibble_out = display[3:0];
                blanked    = 1'b0;
            end
        endcase
    end

    assign anode = blanked ? 4'b1111 : ~(4'b0001 << idx);

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Self-checking bench for ssd_scan_mux with REFRESH_DIV=4, compared against a
// time-indexed reference model (digit and boundary derived from cycles since reset).
module tb_ssd_scan_mux;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;
    localparam logic [9:0] RESET_OUT = {4'h0, 4'b1110, 1'b0, 1'b0};

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic        blank_lz;
    logic [3:0]  nibble_out;
    logic [3:0]  anode;
    logic        pending;
    logic        frame_tick;

    wire [9:0] obs = {nibble_out, anode, pending, frame_tick};

    int checks = 0;
    int errors = 0;

    // Reference model: t counts clock edges since reset release.
    int          t;
    logic [15:0] m_shadow;
    logic [15:0] m_display;
    logic        m_pending;
    logic        m_ft;

    ssd_scan_mux #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .blank_lz   (blank_lz),
        .nibble_out (nibble_out),
        .anode      (anode),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [9:0] expected();
        int          d;
        logic [15:0] upper;
        logic        blanked;
        logic [3:0]  an;
        d       = (t / DIV) % 4;
        upper   = m_display >> (4 * d);
        blanked = blank_lz && (d != 0) && (upper == 16'h0000);
        an      = blanked ? 4'hF : 4'(15 - (1 << d));
        return {upper[3:0], an, m_pending, m_ft};
    endfunction

    task automatic model_reset();
        t         = 0;
        m_shadow  = 16'h0000;
        m_display = 16'h0000;
        m_pending = 1'b0;
        m_ft      = 1'b0;
    endtask

    // Apply one clock edge to the model with the currently driven inputs, then
    // step the DUT to the next falling edge.
    task automatic advance();
        bit b;
        b = (t % FRAME) == FRAME - 1;
        if (load && b) begin
            m_display = data_in;
            m_shadow  = data_in;
            m_pending = 1'b0;
        end else if (load) begin
            m_shadow  = data_in;
            m_pending = 1'b1;
        end else if (b && m_pending) begin
            m_display = m_shadow;
            m_pending = 1'b0;
        end
        m_ft = b;
        t++;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; data_in = 16'h0000; blank_lz = 1'b0;
        #1;
        checks++;
        if (obs !== RESET_OUT) begin
            errors++;
            $display("FAIL reset_no_edge: got %h expected %h", obs, RESET_OUT);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== RESET_OUT) begin
            errors++;
            $display("FAIL reset_held: got %h expected %h", obs, RESET_OUT);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_scan();
        int last = -1;
        int periods = 0;
        load = 1'b1; data_in = 16'h1234; blank_lz = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            #1;
            checks++;
            if (obs !== expected()) begin
                errors++;
                $display("FAIL scan t=%0d: got %h expected %h", t, obs, expected());
            end
            if (frame_tick === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    periods++;
                    if (i - last !== FRAME) begin
                        errors++;
                        $display("FAIL frame_period: got %0d expected %0d", i - last, FRAME);
                    end
                end
                last = i;
            end
            advance();
        end
        checks++;
        if (periods < 2) begin
            errors++;
            $display("FAIL frame_tick_count: got %0d periods expected at least 2", periods);
        end
    endtask

    task automatic test_deferred();
        while (!((t % FRAME) == DIV + 1)) begin
            #1;
            checks++;
            if (obs !== expected()) begin
                errors++;
                $display("FAIL deferred_pre t=%0d: got %h expected %h", t, obs, expected());
            end
            advance();
        end
        load = 1'b1; data_in = 16'hABCD;
        #1;
        checks++;
        if (obs !== expected()) begin
            errors++;
            $display("FAIL deferred_load t=%0d: got %h expected %h", t, obs, expected());
        end
        advance();
        while ((t % FRAME) != 0) begin
            #1;
            checks++;
            if (obs !== expected()) begin
                errors++;
                $display("FAIL deferred_wait t=%0d: got %h expected %h", t, obs, expected());
            end
            advance();
        end
        #1;
        checks++;
        if (nibble_out !== 4'hD || pending !== 1'b0 || anode !== 4'b1110) begin
            errors++;
            $display("FAIL deferred_swap: got nib=%h pend=%b an=%b expected nib=d pend=0 an=1110",
                     nibble_out, pending, anode);
        end
        advance();
    endtask

    task automatic test_boundary_load();
        while ((t % FRAME) != FRAME - 1) begin
            #1;
            checks++;
            if (obs !== expected()) begin
                errors++;
                $display("FAIL bload_pre t=%0d: got %h expected %h", t, obs, expected());
            end
            advance();
        end
        load = 1'b1; data_in = 16'h5678;
        #1;
        advance();
        #1;
        checks++;
        if (nibble_out !== 4'h8 || pending !== 1'b0 || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL boundary_load: got nib=%h pend=%b ft=%b expected nib=8 pend=0 ft=1",
                     nibble_out, pending, frame_tick);
        end
        advance();
    endtask

    task automatic test_blanking();
        logic [15:0] pats [3] = '{16'h0005, 16'h0000, 16'h0005};
        logic        bls  [3] = '{1'b1, 1'b1, 1'b0};
        int          exp_blanks [3] = '{12, 12, 0};
        for (int p = 0; p < 3; p++) begin
            int blanks = 0;
            logic [15:0] pat;
            pat = pats[p];
            while ((t % FRAME) != FRAME - 1) begin
                #1;
                checks++;
                if (obs !== expected()) begin
                    errors++;
                    $display("FAIL blank_pre t=%0d: got %h expected %h", t, obs, expected());
                end
                advance();
            end
            load = 1'b1; data_in = pat; blank_lz = bls[p];
            #1;
            advance();
            for (int i = 0; i < FRAME; i++) begin
                #1;
                checks++;
                if (obs !== expected()) begin
                    errors++;
                    $display("FAIL blank p=%0d t=%0d: got %h expected %h", p, t, obs, expected());
                end
                if (anode === 4'hF) blanks++;
                if (anode === 4'b1110 && nibble_out !== pat[3:0]) begin
                    errors++;
                    $display("FAIL blank_digit0 p=%0d: got %h expected %h", p, nibble_out, pat[3:0]);
                end
                advance();
            end
            checks++;
            if (blanks !== exp_blanks[p]) begin
                errors++;
                $display("FAIL blank_count p=%0d: got %0d expected %0d", p, blanks, exp_blanks[p]);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while ((t % FRAME) != DIV + 1) begin
            #1;
            advance();
        end
        load = 1'b1; data_in = 16'h9E3F;
        #1;
        advance();
        while ((t % FRAME) != 2 * DIV + 1) begin
            #1;
            checks++;
            if (obs !== expected()) begin
                errors++;
                $display("FAIL rmid_pre t=%0d: got %h expected %h", t, obs, expected());
            end
            advance();
        end
        #1;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pending: got %b expected 1", pending);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== RESET_OUT) begin
            errors++;
            $display("FAIL rmid_async: got %h expected %h", obs, RESET_OUT);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (obs !== expected()) begin
                errors++;
                $display("FAIL rmid_post t=%0d: got %h expected %h", t, obs, expected());
            end
            if (anode !== 4'b1110) break;
            n++;
            advance();
        end
        checks++;
        if (n !== DIV) begin
            errors++;
            $display("FAIL rmid_dwell: got %0d cycles expected %0d", n, DIV);
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            load     = ($urandom_range(0, 7) == 0);
            data_in  = 16'($urandom);
            blank_lz = 1'($urandom);
            #1;
            checks++;
            if (obs !== expected()) begin
                errors++;
                $display("FAIL random t=%0d: got %h expected %h", t, obs, expected());
            end
            advance();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan();
        test_deferred();
        test_boundary_load();
        test_blanking();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_mux.md
SSD_SCAN_MUX -- requirements
Module: ssd_scan_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles each digit stays lit; legal range >= 2.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port load  input  1  one-cycle request to capture data_in.
REQ-005 SHALL have port data_in  input  16  four hex digits; [3:0] is digit 0, the least significant.
REQ-006 SHALL have port blank_lz  input  1  leading-zero blanking enable, sampled every cycle.
REQ-007 SHALL have port nibble_out  output  4  hex code of the active digit, feeding the downstream seven-segment decoder.
REQ-008 SHALL have port anode  output  4  active-low digit enables; bit k drives digit k.
REQ-009 SHALL have port pending  output  1  high while captured data waits for a frame boundary.
REQ-010 SHALL have port frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-011 SHALL hold a prescaler counting 0..REFRESH_DIV-1 and wrapping to 0; the terminal-count cycle is the "digit tick".
REQ-012 SHALL hold a 2-bit digit index that increments on each digit tick and wraps 3 -> 0.
REQ-013 SHALL define the frame boundary as the digit tick with index = 3; frame_tick SHALL be registered and high for exactly the cycle after that boundary edge.
REQ-014 SHALL hold a 16-bit shadow register and a 16-bit display register.
REQ-015 On load=1 not at a frame boundary, SHALL write data_in to shadow and set pending=1; display is unchanged.
REQ-016 At a frame boundary with pending=1 and load=0, SHALL copy shadow to display and clear pending.
REQ-017 On load=1 coinciding with a frame boundary, SHALL write data_in directly to display and shadow, and pending SHALL be 0 afterwards.
REQ-018 Repeated loads before a boundary SHALL overwrite shadow; only the last value is displayed.
REQ-019 nibble_out SHALL equal display[4*idx+3 : 4*idx], combinational from registered state; there is no added latency.
REQ-020 anode SHALL equal ~(4'b0001 << idx) unless the current digit is blanked, in which case anode SHALL be 4'b1111.
REQ-021 With blank_lz=1, digit k (k=1..3) SHALL be blanked iff display digits k..3 are all zero; digit 0 SHALL never be blanked.
REQ-022 With blank_lz=0, no digit SHALL be blanked.
REQ-023 Exactly zero or one anode bit SHALL be low in any cycle.
REQ-024 The display register SHALL change only at frame boundaries, so no frame shows a mix of old and new digits.

Reset
REQ-025 rst=1 SHALL immediately, without a clock edge, force the following:
- prescaler = 0, idx = 0
- shadow = 16'h0000, display = 16'h0000
- pending = 0, frame_tick = 0
- nibble_out = 4'h0, anode = 4'b1110
REQ-026 Reset asserted mid-frame with pending=1 SHALL discard the shadow data; after release, scanning restarts at digit 0 with a full REFRESH_DIV dwell.

Verification (REFRESH_DIV=4)
REQ-027 Reset check: assert rst -> anode=4'b1110, nibble_out=0, pending=0, frame_tick=0 before any clock edge.
REQ-028 Scan and dwell check: load 16'h1234, then free-run -> after the next boundary the bench sees:
- nibble 4/3/2/1 with anode 1110/1101/1011/0111
- each digit held 4 cycles
- frame_tick period of 16 cycles
REQ-029 Deferred update check:
- stimulus: load 16'hABCD at idx=1, mid-frame
- response: pending=1 and the old value is still shown through idx 2 and 3; at the boundary, digit 0 shows D and pending=0
REQ-030 Simultaneous load at boundary: load 16'h5678 on the boundary cycle -> pending stays 0 and the next digit 0 shows 8.
REQ-031 Leading-zero blanking check:
- 16'h0005 with blank_lz=1: digits 1-3 give anode=1111; digit 0 gives anode=1110, nibble 5
- 16'h0000: digit 0 shows 0
- 16'h0005 with blank_lz=0: all four digits are lit
REQ-032 Reset mid-operation: assert rst at idx=2 with pending=1 -> outputs return to their reset values, display=0 after release, and the next digit tick occurs 4 cycles after release.
